// File: rtl/sha3_burst_feeder.sv
// sha3_burst_feeder
//   Queues absorbed 1600-bit Keccak states and, on a gimme request from the
//   6-round iterating SHA3 pipe, drives one burst of exactly BURST_LEN
//   consecutive slots with sample high. Slots with no queued state carry an
//   all-zero bubble. A per-burst slot mask lets the result collector discard
//   the bubbles.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready upstream handshake; push = in_valid & in_ready
//   in_a..in_e        upstream state rows, lane k at bits [64k+63:64k]
//   gimme             pipe accepts a new burst
//   sample            slot valid to pipe, high for BURST_LEN cycles per burst
//   ina..ine          registered state to pipe, aligned with sample
//   burst_mask        bit i set = slot i carried a real state
//   mask_valid        one-cycle strobe on the last slot qualifying burst_mask
module sha3_burst_feeder #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned BURST_LEN     = 14,
  parameter int unsigned FLUSH_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [319:0]         in_a,
  input  logic [319:0]         in_b,
  input  logic [319:0]         in_c,
  input  logic [319:0]         in_d,
  input  logic [319:0]         in_e,
  input  logic                 gimme,
  output logic                 sample,
  output logic [319:0]         ina,
  output logic [319:0]         inb,
  output logic [319:0]         inc,
  output logic [319:0]         ind,
  output logic [319:0]         ine,
  output logic [BURST_LEN-1:0] burst_mask,
  output logic                 mask_valid
);

  localparam int unsigned ROW_W   = 320;
  localparam int unsigned STATE_W = 5 * ROW_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SLOT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TMO_W   = $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_BURST = CNT_W'(BURST_LEN);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(FLUSH_TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [BURST_LEN-1:0] acc_q, acc_d;
  logic                 low_seen_q, low_seen_d;
  logic                 sample_q, sample_d;
  logic                 mask_valid_q, mask_valid_d;
  logic [BURST_LEN-1:0] burst_mask_q, burst_mask_d;
  logic [STATE_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 in_ready_q, in_ready_d;
  logic [STATE_W-1:0]   mem_q [DEPTH];
  logic                 push;
  logic                 pop;
  logic                 partial;

  assign push    = in_valid & in_ready_q;
  assign partial = (count_q != '0) && (count_q < CNT_BURST);

  // Burst sequencer: start decision, slot fill, post-burst gimme re-arm
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    tmo_d        = '0;
    acc_d        = acc_q;
    low_seen_d   = low_seen_q;
    sample_d     = 1'b0;
    mask_valid_d = 1'b0;
    burst_mask_d = burst_mask_q;
    out_d        = out_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gimme && ((count_q >= CNT_BURST) || ((tmo_q == TMO_MAX) && (count_q != '0)))) begin
          state_d = ST_BURST;
          slot_d  = '0;
          acc_d   = '0;
        end else if (partial) begin
          // Saturate so an expired timeout stays expired until gimme arrives
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        end
      end
      ST_BURST: begin
        sample_d      = 1'b1;
        pop           = (count_q != '0);
        out_d         = pop ? mem_q[rd_ptr_q] : '0;
        acc_d[slot_q] = pop;
        if (slot_q == SLOT_LAST) begin
          mask_valid_d = 1'b1;
          burst_mask_d = acc_d;
          low_seen_d   = 1'b0;
          state_d      = ST_WAIT;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      ST_WAIT: begin
        // A gimme left high from the previous request must drop before re-arming
        if (!gimme) begin
          low_seen_d = 1'b1;
        end else if (low_seen_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy and pointers
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      tmo_q        <= '0;
      acc_q        <= '0;
      low_seen_q   <= 1'b0;
      sample_q     <= 1'b0;
      mask_valid_q <= 1'b0;
      burst_mask_q <= '0;
      out_q        <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      tmo_q        <= tmo_d;
      acc_q        <= acc_d;
      low_seen_q   <= low_seen_d;
      sample_q     <= sample_d;
      mask_valid_q <= mask_valid_d;
      burst_mask_q <= burst_mask_d;
      out_q        <= out_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // State storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_e, in_d, in_c, in_b, in_a};
    end
  end

  assign in_ready   = in_ready_q;
  assign sample     = sample_q;
  assign mask_valid = mask_valid_q;
  assign burst_mask = burst_mask_q;
  assign ina        = out_q[0*ROW_W +: ROW_W];
  assign inb        = out_q[1*ROW_W +: ROW_W];
  assign inc        = out_q[2*ROW_W +: ROW_W];
  assign ind        = out_q[3*ROW_W +: ROW_W];
  assign ine        = out_q[4*ROW_W +: ROW_W];

endmodule

// File: tb/tb_sha3_burst_feeder.sv
module tb_sha3_burst_feeder;

  localparam logic [63:0] E_KEY = 64'hDEAD_BEEF_0BAD_F00D;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] in_a, in_b, in_c, in_d, in_e;
  logic         gimme;
  logic         sample;
  logic [319:0] ina, inb, inc, ind, ine;
  logic [13:0]  burst_mask;
  logic         mask_valid;

  int tests_run;
  int tests_failed;

  int          cap_a[$];
  logic [63:0] cap_e[$];
  bit          cap_zero[$];
  int          cap_first, cap_last, cap_mv, cap_mv_slot;
  logic [13:0] cap_mask;

  sha3_burst_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .gimme(gimme), .sample(sample),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind), .ine(ine),
    .burst_mask(burst_mask), .mask_valid(mask_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_state(input int v);
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
    in_a[63:0]    = 64'(v);
    in_b[127:64]  = 64'(v) << 8;
    in_e[319:256] = 64'(v) ^ E_KEY;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; gimme = 1'b0;
    drive_state(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pushes n consecutive values starting at first; returns on the negedge after the last push
  task automatic push_n(input int first, input int n);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (in_ready) begin
        in_valid = 1'b1; drive_state(first + k); k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (k != n) begin
      tests_failed++;
      $display("FAIL push_n budget: pushed %0d, required %0d", k, n);
    end
  endtask

  // Records sample slots for max_cycles negedges; optionally feeds pushes meanwhile
  task automatic collect(input int max_cycles, input int feed_first, input int feed_n);
    int fed = 0;
    cap_a.delete(); cap_e.delete(); cap_zero.delete();
    cap_first = -1; cap_last = -1; cap_mv = 0; cap_mv_slot = -1; cap_mask = '0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (sample) begin
        if (cap_first < 0) cap_first = c;
        cap_last = c;
        cap_a.push_back(int'(ina[31:0]));
        cap_e.push_back(ine[319:256]);
        cap_zero.push_back({ine, ind, inc, inb, ina} == '0);
      end
      if (mask_valid) begin
        cap_mv++; cap_mask = burst_mask; cap_mv_slot = cap_a.size();
      end
      if (fed < feed_n && in_ready) begin
        in_valid = 1'b1; drive_state(feed_first + fed); fed++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if (sample !== 1'b0) begin tests_failed++; $display("FAIL reset_sample: got %b want 0", sample); end
    tests_run++;
    if (mask_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mask_valid: got %b want 0", mask_valid); end
    tests_run++;
    if (burst_mask !== 14'h0) begin tests_failed++; $display("FAIL reset_burst_mask: got %h want 0", burst_mask); end
    tests_run++;
    if ({ine, ind, inc, inb, ina} !== '0) begin tests_failed++; $display("FAIL reset_state: output state not zero"); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_burst();
    do_reset();
    push_n(1, 14);
    gimme = 1'b1;
    collect(24, 0, 0);
    tests_run++;
    if (cap_a.size() != 14) begin tests_failed++; $display("FAIL full_count: got %0d want 14", cap_a.size()); end
    tests_run++;
    if (cap_first != 2) begin tests_failed++; $display("FAIL full_latency: got %0d want 2", cap_first); end
    tests_run++;
    if (cap_last - cap_first + 1 != 14) begin tests_failed++; $display("FAIL full_consecutive: span %0d want 14", cap_last - cap_first + 1); end
    for (int i = 0; i < cap_a.size() && i < 14; i++) begin
      tests_run++;
      if (cap_a[i] != i + 1) begin tests_failed++; $display("FAIL full_slot%0d_a: got %0d want %0d", i, cap_a[i], i + 1); end
      tests_run++;
      if (cap_e[i] !== (64'(i + 1) ^ E_KEY)) begin tests_failed++; $display("FAIL full_slot%0d_e4: got %h want %h", i, cap_e[i], 64'(i + 1) ^ E_KEY); end
    end
    tests_run++;
    if (cap_mv != 1 || cap_mv_slot != 14) begin tests_failed++; $display("FAIL full_mask_valid: count %0d at slot %0d want 1 at 14", cap_mv, cap_mv_slot); end
    tests_run++;
    if (cap_mask !== 14'h3FFF) begin tests_failed++; $display("FAIL full_mask: got %h want 3fff", cap_mask); end
    // Re-arm gimme: an empty FIFO must not produce a burst
    gimme = 1'b0;
    @(negedge clk);
    gimme = 1'b1;
    collect(50, 0, 0);
    tests_run++;
    if (cap_a.size() != 0) begin tests_failed++; $display("FAIL full_empty_after: got %0d slots want 0", cap_a.size()); end
    tests_run++;
    if (burst_mask !== 14'h3FFF) begin tests_failed++; $display("FAIL full_mask_hold: got %h want 3fff", burst_mask); end
  endtask

  task automatic test_partial_timeout();
    do_reset();
    gimme = 1'b1;
    collect(40, 0, 0);
    tests_run++;
    if (cap_a.size() != 0) begin tests_failed++; $display("FAIL empty_no_start: got %0d slots want 0", cap_a.size()); end
    push_n(101, 3);
    collect(50, 0, 0);
    tests_run++;
    if (cap_first != 32) begin tests_failed++; $display("FAIL partial_timeout_start: got %0d want 32", cap_first); end
    tests_run++;
    if (cap_a.size() != 14) begin tests_failed++; $display("FAIL partial_count: got %0d want 14", cap_a.size()); end
    for (int i = 0; i < cap_a.size() && i < 14; i++) begin
      tests_run++;
      if (i < 3) begin
        if (cap_a[i] != 101 + i) begin tests_failed++; $display("FAIL partial_slot%0d: got %0d want %0d", i, cap_a[i], 101 + i); end
      end else begin
        if (cap_zero[i] !== 1'b1) begin tests_failed++; $display("FAIL partial_bubble%0d: state not zero (a=%0d)", i, cap_a[i]); end
      end
    end
    tests_run++;
    if (cap_mask !== 14'h0007 || cap_mv != 1) begin tests_failed++; $display("FAIL partial_mask: got %h (strobes %0d) want 0007 (1)", cap_mask, cap_mv); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    bit saw_sample = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample) saw_sample = 1'b1;
      if (in_ready) begin
        in_valid = 1'b1; drive_state(accepted + 1); accepted++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (accepted != 16) begin tests_failed++; $display("FAIL bp_accepted: got %0d want 16", accepted); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    tests_run++;
    if (saw_sample !== 1'b0) begin tests_failed++; $display("FAIL bp_no_sample: got %b want 0", saw_sample); end
    gimme = 1'b1;
    collect(20, 0, 0);
    tests_run++;
    if (cap_a.size() != 14 || cap_first != 2) begin tests_failed++; $display("FAIL bp_burst: %0d slots from %0d want 14 from 2", cap_a.size(), cap_first); end
    tests_run++;
    if (cap_a.size() == 14 && (cap_a[0] != 1 || cap_a[13] != 14)) begin tests_failed++; $display("FAIL bp_order: first %0d last %0d want 1 14", cap_a[0], cap_a[13]); end
    tests_run++;
    if (cap_mask !== 14'h3FFF) begin tests_failed++; $display("FAIL bp_mask: got %h want 3fff", cap_mask); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    // Two leftovers flush after the idle timeout once gimme is re-armed
    gimme = 1'b0;
    @(negedge clk);
    gimme = 1'b1;
    collect(60, 0, 0);
    tests_run++;
    if (cap_first != 35) begin tests_failed++; $display("FAIL bp_rest_start: got %0d want 35", cap_first); end
    tests_run++;
    if (cap_a.size() != 14 || cap_a[0] != 15 || cap_a[1] != 16) begin tests_failed++; $display("FAIL bp_rest_data: %0d slots, head %0d want 14 slots head 15,16", cap_a.size(), (cap_a.size() > 0) ? cap_a[0] : -1); end
    tests_run++;
    if (cap_mask !== 14'h0003) begin tests_failed++; $display("FAIL bp_rest_mask: got %h want 0003", cap_mask); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_n(1, 14);
    gimme = 1'b1;
    collect(24, 15, 14);
    tests_run++;
    if (cap_a.size() != 14) begin tests_failed++; $display("FAIL b2b_count: got %0d want 14", cap_a.size()); end
    for (int i = 0; i < cap_a.size() && i < 14; i++) begin
      tests_run++;
      if (cap_a[i] != i + 1) begin tests_failed++; $display("FAIL b2b_slot%0d: got %0d want %0d", i, cap_a[i], i + 1); end
    end
    tests_run++;
    if (cap_mask !== 14'h3FFF || cap_mv != 1) begin tests_failed++; $display("FAIL b2b_mask: got %h (strobes %0d) want 3fff (1)", cap_mask, cap_mv); end
    collect(40, 0, 0);
    tests_run++;
    if (cap_a.size() != 0) begin tests_failed++; $display("FAIL b2b_stale_gimme: got %0d slots want 0", cap_a.size()); end
    gimme = 1'b0;
    @(negedge clk);
    gimme = 1'b1;
    collect(24, 0, 0);
    tests_run++;
    if (cap_first != 3 || cap_a.size() != 14) begin tests_failed++; $display("FAIL b2b_second: %0d slots from %0d want 14 from 3", cap_a.size(), cap_first); end
    for (int i = 0; i < cap_a.size() && i < 14; i++) begin
      tests_run++;
      if (cap_a[i] != i + 15) begin tests_failed++; $display("FAIL b2b_second_slot%0d: got %0d want %0d", i, cap_a[i], i + 15); end
    end
    tests_run++;
    if (cap_mask !== 14'h3FFF) begin tests_failed++; $display("FAIL b2b_second_mask: got %h want 3fff", cap_mask); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_n(1, 14);
    gimme = 1'b1;
    collect(7, 0, 0);
    tests_run++;
    if (cap_a.size() != 6 || cap_a[5] != 6) begin tests_failed++; $display("FAIL rmb_pre: %0d slots want 6 ending at 6", cap_a.size()); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (sample !== 1'b0) begin tests_failed++; $display("FAIL rmb_sample: got %b want 0", sample); end
    tests_run++;
    if (mask_valid !== 1'b0 || burst_mask !== 14'h0) begin tests_failed++; $display("FAIL rmb_mask: valid %b mask %h want 0 0", mask_valid, burst_mask); end
    tests_run++;
    if ({ine, ind, inc, inb, ina} !== '0) begin tests_failed++; $display("FAIL rmb_state: output state not zero (a=%0d)", int'(ina[31:0])); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rmb_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    collect(50, 0, 0);
    tests_run++;
    if (cap_a.size() != 0) begin tests_failed++; $display("FAIL rmb_no_resume: got %0d slots want 0", cap_a.size()); end
    push_n(200, 1);
    collect(50, 0, 0);
    tests_run++;
    if (cap_first != 34 || cap_a.size() != 14) begin tests_failed++; $display("FAIL rmb_new_burst: %0d slots from %0d want 14 from 34", cap_a.size(), cap_first); end
    tests_run++;
    if (cap_a.size() > 0 && cap_a[0] != 200) begin tests_failed++; $display("FAIL rmb_new_data: got %0d want 200", cap_a[0]); end
    tests_run++;
    if (cap_mask !== 14'h0001) begin tests_failed++; $display("FAIL rmb_new_mask: got %h want 0001", cap_mask); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; gimme = 1'b0;
    drive_state(0);
    test_reset();
    test_full_burst();
    test_partial_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
